axi4_b_sender: RTL and testbench

AXI4_B_SENDER -- requirements
Module: axi4_b_sender

---
 rtl/axi4_b_sender_pkg.sv | 14 +
 rtl/axi_buffer_rab.sv | 54 +++++
 rtl/axi4_b_sender.sv | 107 ++++++++++
 tb/tb_axi4_b_sender.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_b_sender_pkg.sv
// Shared RAB definitions: B-channel response codes and the B sender FSM states.
package axi4_b_sender_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    ERR_WAIT = 2'd2,
    ERR_SEND = 2'd3
  } b_state_e;

endpackage

// File: rtl/axi_buffer_rab.sv
// Small synchronous FIFO with valid/ready on both sides; ready_out is held low
// through reset and rises on the first clock after release.
module axi_buffer_rab #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          alive;
  logic          push, pop;

  assign ready_out = alive && (count != CW'(BUFFER_DEPTH));
  assign valid_out = (count != '0);
  assign data_out  = mem[rd_ptr];
  assign push      = valid_in & ready_out;
  assign pop       = ready_in & valid_out;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/axi4_b_sender.sv
// B-channel sender: forwards master responses and injects locally generated
// SLVERR responses for dropped writes, which take priority over the master.
module axi4_b_sender
  import axi4_b_sender_pkg::*;
#(
  parameter int AXI_ID_WIDTH    = 10,
  parameter int AXI_USER_WIDTH  = 2,
  parameter int ENABLE_L2TLB    = 0,
  parameter int DROP_FIFO_DEPTH = 4
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  input  logic                      drop,
  input  logic [AXI_ID_WIDTH-1:0]   drop_id,
  input  logic [AXI_USER_WIDTH-1:0] drop_user,
  input  logic                      drop_l2,
  output logic                      drop_ready,
  input  logic                      wlast_received,
  output logic                      response_sent,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
  output logic                      s_axi4_bvalid,
  input  logic                      s_axi4_bready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                m_axi4_bresp,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
  input  logic                      m_axi4_bvalid,
  output logic                      m_axi4_bready
);

  localparam int DW = AXI_ID_WIDTH + AXI_USER_WIDTH + 1;

  b_state_e                  state;
  logic [DW-1:0]             fifo_dout;
  logic                      fifo_valid, fifo_pop, push;
  logic [AXI_ID_WIDTH-1:0]   head_id;
  logic [AXI_USER_WIDTH-1:0] head_user;
  logic                      head_l2, next_l2;

  assign push      = drop & drop_ready;
  assign head_id   = fifo_dout[DW-1 -: AXI_ID_WIDTH];
  assign head_user = fifo_dout[AXI_USER_WIDTH:1];
  assign head_l2   = fifo_dout[0];
  // A drop arriving into an empty FIFO is already the head for the IDLE decision.
  assign next_l2   = fifo_valid ? head_l2 : drop_l2;
  assign fifo_pop  = (state == ERR_SEND) && s_axi4_bready;

  axi_buffer_rab #(
    .DATA_WIDTH  (DW),
    .BUFFER_DEPTH(DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk      (axi4_aclk),
    .rst      (axi4_arst),
    .valid_in (drop),
    .ready_out(drop_ready),
    .data_in  ({drop_id, drop_user, drop_l2}),
    .valid_out(fifo_valid),
    .ready_in (fifo_pop),
    .data_out (fifo_dout)
  );

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:
          if (fifo_valid || push)
            state <= (next_l2 && (ENABLE_L2TLB != 0)) ? ERR_WAIT : ERR_SEND;
          else if (m_axi4_bvalid)
            state <= FWD;
        FWD:      if (m_axi4_bvalid && s_axi4_bready) state <= IDLE;
        ERR_WAIT: if (wlast_received) state <= ERR_SEND;
        ERR_SEND: if (s_axi4_bready) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_axi4_bid    = '0;
    s_axi4_bresp  = RESP_OKAY;
    s_axi4_buser  = '0;
    s_axi4_bvalid = 1'b0;
    m_axi4_bready = 1'b0;
    case (state)
      FWD: begin
        s_axi4_bid    = m_axi4_bid;
        s_axi4_bresp  = m_axi4_bresp;
        s_axi4_buser  = m_axi4_buser;
        s_axi4_bvalid = m_axi4_bvalid;
        m_axi4_bready = s_axi4_bready;
      end
      ERR_SEND: begin
        s_axi4_bid    = head_id;
        s_axi4_bresp  = RESP_SLVERR;
        s_axi4_buser  = head_user;
        s_axi4_bvalid = 1'b1;
      end
      default: ;
    endcase
  end

  assign response_sent = fifo_pop & head_l2;

endmodule

// File: tb/tb_axi4_b_sender.sv
// Directed and randomized checks of the B sender against a response-order model.
module tb_axi4_b_sender;

  logic       axi4_aclk = 1'b0;
  logic       axi4_arst;
  logic       drop, drop_l2, drop_ready, wlast_received, response_sent;
  logic [9:0] drop_id, s_axi4_bid, m_axi4_bid;
  logic [1:0] drop_user, s_axi4_buser, m_axi4_buser, s_axi4_bresp, m_axi4_bresp;
  logic       s_axi4_bvalid, s_axi4_bready, m_axi4_bvalid, m_axi4_bready;

  typedef struct packed {
    logic [9:0] id;
    logic [1:0] user;
    logic       l2;
  } drop_t;

  drop_t      dq[$];
  logic [9:0] got[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic       m_done, hold;
  logic [9:0] h_id;
  logic [1:0] h_resp, h_user;

  always #5 axi4_aclk = ~axi4_aclk;

  axi4_b_sender #(
    .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(2), .ENABLE_L2TLB(1), .DROP_FIFO_DEPTH(4)
  ) dut (
    .axi4_aclk(axi4_aclk), .axi4_arst(axi4_arst),
    .drop(drop), .drop_id(drop_id), .drop_user(drop_user), .drop_l2(drop_l2),
    .drop_ready(drop_ready), .wlast_received(wlast_received), .response_sent(response_sent),
    .s_axi4_bid(s_axi4_bid), .s_axi4_bresp(s_axi4_bresp), .s_axi4_buser(s_axi4_buser),
    .s_axi4_bvalid(s_axi4_bvalid), .s_axi4_bready(s_axi4_bready),
    .m_axi4_bid(m_axi4_bid), .m_axi4_bresp(m_axi4_bresp), .m_axi4_buser(m_axi4_buser),
    .m_axi4_bvalid(m_axi4_bvalid), .m_axi4_bready(m_axi4_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge axi4_aclk);
  endtask

  task automatic set_drop(input logic [9:0] id, input logic [1:0] user, input logic l2);
    drop = 1'b1; drop_id = id; drop_user = user; drop_l2 = l2;
  endtask

  // Scoreboard step at a sample point: a response handshakes at the next edge.
  task automatic check_hs();
    drop_t d;
    if (s_axi4_bvalid && s_axi4_bready) begin
      if (m_axi4_bready) begin
        chk("fwd_id", 32'(s_axi4_bid), 32'(m_axi4_bid));
        chk("fwd_resp", 32'(s_axi4_bresp), 32'(m_axi4_bresp));
        chk("fwd_user", 32'(s_axi4_buser), 32'(m_axi4_buser));
        m_done = 1'b1;
      end else if (dq.size() == 0) begin
        chk("spurious_err", 32'(s_axi4_bvalid), 32'd0);
      end else begin
        d = dq.pop_front();
        chk("err_id", 32'(s_axi4_bid), 32'(d.id));
        chk("err_resp", 32'(s_axi4_bresp), 32'd2);
        chk("err_user", 32'(s_axi4_buser), 32'(d.user));
        chk("err_rsent", 32'(response_sent), 32'(d.l2));
      end
    end
    if (drop && drop_ready) dq.push_back({drop_id, drop_user, drop_l2});
  endtask

  task automatic check_hold();
    if (hold) begin
      chk("hold_valid", 32'(s_axi4_bvalid), 32'd1);
      chk("hold_id", 32'(s_axi4_bid), 32'(h_id));
      chk("hold_resp", 32'(s_axi4_bresp), 32'(h_resp));
      chk("hold_user", 32'(s_axi4_buser), 32'(h_user));
    end
    hold = s_axi4_bvalid && !s_axi4_bready;
    h_id = s_axi4_bid; h_resp = s_axi4_bresp; h_user = s_axi4_buser;
  endtask

  initial begin
    axi4_arst = 1'b1; drop = 1'b0; drop_id = '0; drop_user = '0; drop_l2 = 1'b0;
    wlast_received = 1'b0; s_axi4_bready = 1'b0;
    m_axi4_bvalid = 1'b0; m_axi4_bid = '0; m_axi4_bresp = '0; m_axi4_buser = '0;
    m_done = 1'b0; hold = 1'b0; h_id = '0; h_resp = '0; h_user = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_bvalid", 32'(s_axi4_bvalid), 32'd0);
    chk("rst_mready", 32'(m_axi4_bready), 32'd0);
    chk("rst_rsent", 32'(response_sent), 32'd0);
    chk("rst_dready", 32'(drop_ready), 32'd0);
    chk("rst_bid", 32'(s_axi4_bid), 32'd0);
    axi4_arst = 1'b0;
    cyc();
    chk("rel_dready", 32'(drop_ready), 32'd1);

    // Forward a master OKAY response
    m_axi4_bvalid = 1'b1; m_axi4_bid = 10'h005; m_axi4_bresp = 2'b00; s_axi4_bready = 1'b1;
    #1 chk("fwd_lat_bvalid", 32'(s_axi4_bvalid), 32'd0);
    cyc();
    chk("fwd_bvalid", 32'(s_axi4_bvalid), 32'd1);
    chk("fwd_bid", 32'(s_axi4_bid), 32'h5);
    chk("fwd_bresp", 32'(s_axi4_bresp), 32'd0);
    chk("fwd_mready", 32'(m_axi4_bready), 32'd1);
    cyc();
    m_axi4_bvalid = 1'b0;
    #1 chk("fwd_done", 32'(s_axi4_bvalid), 32'd0);

    // Non-L2 drop: immediate SLVERR, no response_sent
    s_axi4_bready = 1'b0; set_drop(10'h003, 2'd1, 1'b0);
    cyc(); drop = 1'b0;
    chk("d_bvalid", 32'(s_axi4_bvalid), 32'd1);
    chk("d_bid", 32'(s_axi4_bid), 32'h3);
    chk("d_bresp", 32'(s_axi4_bresp), 32'd2);
    chk("d_buser", 32'(s_axi4_buser), 32'd1);
    chk("d_mready", 32'(m_axi4_bready), 32'd0);
    s_axi4_bready = 1'b1;
    #1 chk("d_rsent", 32'(response_sent), 32'd0);
    cyc();
    chk("d_done", 32'(s_axi4_bvalid), 32'd0);

    // L2 drop waits for wlast_received raised 10 cycles later
    set_drop(10'h007, 2'd2, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      drop = 1'b0;
      chk("l2_wait_bvalid", 32'(s_axi4_bvalid), 32'd0);
      chk("l2_wait_rsent", 32'(response_sent), 32'd0);
    end
    wlast_received = 1'b1;
    cyc();
    chk("l2_bvalid", 32'(s_axi4_bvalid), 32'd1);
    chk("l2_bid", 32'(s_axi4_bid), 32'h7);
    chk("l2_buser", 32'(s_axi4_buser), 32'd2);
    chk("l2_bresp", 32'(s_axi4_bresp), 32'd2);
    chk("l2_rsent", 32'(response_sent), 32'd1);
    cyc();
    chk("l2_rsent_pulse", 32'(response_sent), 32'd0);
    chk("l2_done", 32'(s_axi4_bvalid), 32'd0);
    wlast_received = 1'b0;

    // Drop and master response in the same cycle: drop wins
    s_axi4_bready = 1'b0; set_drop(10'h009, 2'd0, 1'b0);
    m_axi4_bvalid = 1'b1; m_axi4_bid = 10'h011; m_axi4_bresp = 2'b00; m_axi4_buser = 2'd1;
    cyc(); drop = 1'b0;
    chk("pri_err_bid", 32'(s_axi4_bid), 32'h9);
    chk("pri_err_bresp", 32'(s_axi4_bresp), 32'd2);
    chk("pri_err_mready", 32'(m_axi4_bready), 32'd0);
    s_axi4_bready = 1'b1;
    cyc();
    chk("pri_gap_bvalid", 32'(s_axi4_bvalid), 32'd0);
    chk("pri_gap_mready", 32'(m_axi4_bready), 32'd0);
    cyc();
    chk("pri_fwd_bid", 32'(s_axi4_bid), 32'h11);
    chk("pri_fwd_bresp", 32'(s_axi4_bresp), 32'd0);
    chk("pri_fwd_mready", 32'(m_axi4_bready), 32'd1);
    cyc();
    m_axi4_bvalid = 1'b0;

    // Fill the FIFO with bready low; 5th drop is ignored
    s_axi4_bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_drop(10'(10'h00A + i), 2'(i), 1'b0);
      cyc();
    end
    chk("full_dready", 32'(drop_ready), 32'd0);
    set_drop(10'h00E, 2'd0, 1'b0);
    cyc();
    drop = 1'b0; s_axi4_bready = 1'b1;
    #1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) cyc();
      if (j == 1) chk("pop_full_dready", 32'(drop_ready), 32'd1);
      if (s_axi4_bvalid && s_axi4_bready) begin
        got.push_back(s_axi4_bid);
        chk("full_bresp", 32'(s_axi4_bresp), 32'd2);
      end
    end
    chk("full_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk("full_order", 32'(got[i]), 32'(10'h00A + i));

    // Randomized traffic checked against the response-order model
    wlast_received = 1'b1; hold = 1'b0; m_done = 1'b0;
    for (int k = 0; k < 800; k++) begin
      cyc();
      check_hold();
      if (m_done) begin m_axi4_bvalid = 1'b0; m_done = 1'b0; end
      if (!m_axi4_bvalid && $urandom_range(0, 3) == 0) begin
        m_axi4_bvalid = 1'b1; m_axi4_bid = 10'($urandom);
        m_axi4_bresp = 2'($urandom); m_axi4_buser = 2'($urandom);
      end
      s_axi4_bready = ($urandom_range(0, 9) < 7);
      drop = 1'b0;
      if (drop_ready && $urandom_range(0, 4) == 0)
        set_drop(10'($urandom), 2'($urandom), 1'($urandom));
      #1 check_hs();
      if (hold == 1'b0 && s_axi4_bvalid && !s_axi4_bready) begin
        hold = 1'b1; h_id = s_axi4_bid; h_resp = s_axi4_bresp; h_user = s_axi4_buser;
      end else if (s_axi4_bready) begin
        hold = 1'b0;
      end
    end
    // Drain with bready high and no new traffic
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (m_done) begin m_axi4_bvalid = 1'b0; m_done = 1'b0; end
      drop = 1'b0; s_axi4_bready = 1'b1;
      #1 check_hs();
      if (dq.size() == 0 && !m_axi4_bvalid) break;
    end
    chk("drain_fifo", 32'(dq.size()), 32'd0);
    cyc();
    if (m_done) begin m_axi4_bvalid = 1'b0; m_done = 1'b0; end
    chk("drain_master", 32'(m_axi4_bvalid), 32'd0);
    wlast_received = 1'b0; hold = 1'b0;

    // FWD held with bready low, then reset mid-handshake
    cyc();
    s_axi4_bready = 1'b0;
    m_axi4_bvalid = 1'b1; m_axi4_bid = 10'h02A; m_axi4_bresp = 2'b00; m_axi4_buser = 2'd3;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      drop = 1'b0;
      chk("stall_bvalid", 32'(s_axi4_bvalid), 32'd1);
      chk("stall_bid", 32'(s_axi4_bid), 32'h2A);
      chk("stall_bresp", 32'(s_axi4_bresp), 32'd0);
      if (i == 1) set_drop(10'h015, 2'd0, 1'b0);
    end
    axi4_arst = 1'b1;
    #1;
    chk("arst_bvalid", 32'(s_axi4_bvalid), 32'd0);
    chk("arst_mready", 32'(m_axi4_bready), 32'd0);
    chk("arst_dready", 32'(drop_ready), 32'd0);
    chk("arst_rsent", 32'(response_sent), 32'd0);
    chk("arst_bid", 32'(s_axi4_bid), 32'd0);
    m_axi4_bvalid = 1'b0;
    cyc();
    axi4_arst = 1'b0; s_axi4_bready = 1'b1;
    cyc();
    chk("rel2_dready", 32'(drop_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("no_replay", 32'(s_axi4_bvalid), 32'd0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
